// File: rtl/lookup_map_interp.sv
// lookup_map_interp
//   Per-channel piecewise-linear transfer curve for the pixel pipeline.
//   Each of NUM_CHANNELS channels has its own table of 2^LUT_ADDR_WIDTH knots.
//   Tables are double-buffered: software programs the shadow bank and then
//   requests a swap. The swap is applied only when the pipeline is empty.
//   The pipeline latency is three pixclk cycles. The sideband (dvi/dtype/meta)
//   is delayed to match.
//
// Ports
//   pixclk, reset          clock, synchronous active-high reset
//   enable, chan_bypass    global / per-channel pass-through (0 / 1 = bypass)
//   lut_we, lut_re         shadow-bank write / read strobes
//   lut_chan, lut_addr     channel and knot index for a LUT access
//   lut_wdata              knot value to write
//   lut_rdata, lut_rvalid  readback data, valid one cycle after lut_re
//   swap_req               pulse requesting a bank swap
//   swap_pending           swap requested but not yet applied
//   active_bank            bank used by the datapath
//   dvi, dtypei, meta_datai, pixi   input pixel and sideband
//   dvo, dtypeo, meta_datao, pixo   delayed and mapped output

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif

module lookup_map_interp #(
    parameter int PIXEL_WIDTH    = 10,
    parameter int NUM_CHANNELS   = 3,
    parameter int LUT_ADDR_WIDTH = 6,
    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                 pixclk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [NUM_CHANNELS-1:0]              chan_bypass,
    input  logic                                 lut_we,
    input  logic                                 lut_re,
    input  logic [CHAN_W-1:0]                    lut_chan,
    input  logic [LUT_ADDR_WIDTH-1:0]            lut_addr,
    input  logic [PIXEL_WIDTH-1:0]               lut_wdata,
    output logic [PIXEL_WIDTH-1:0]               lut_rdata,
    output logic                                 lut_rvalid,
    input  logic                                 swap_req,
    output logic                                 swap_pending,
    output logic                                 active_bank,
    input  logic                                 dvi,
    input  logic [`DTYPE_WIDTH-1:0]              dtypei,
    input  logic [15:0]                          meta_datai,
    input  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0]  pixi,
    output logic                                 dvo,
    output logic [`DTYPE_WIDTH-1:0]              dtypeo,
    output logic [15:0]                          meta_datao,
    output logic [NUM_CHANNELS*PIXEL_WIDTH-1:0]  pixo
);

    localparam int P  = PIXEL_WIDTH;
    localparam int C  = NUM_CHANNELS;
    localparam int A  = LUT_ADDR_WIDTH;
    localparam int F  = P - A;
    localparam int N  = 1 << A;
    localparam int DW = `DTYPE_WIDTH;

    // Knot storage: [bank][channel][knot]. Not cleared by reset.
    logic [P-1:0] lut_q [2][C][N];

    logic          active_bank_q, active_bank_d;
    logic          swap_pending_q, swap_pending_d;
    logic [P-1:0]  lut_rdata_q, lut_rdata_d;
    logic          lut_rvalid_q;
    logic          shadow_bank;
    logic          chan_ok;
    logic          pipe_busy;
    logic          swap_fire;

    // Stage 1: registered input
    logic             s1_valid_q;
    logic [C*P-1:0]   s1_pix_q;
    logic [C-1:0]     s1_map_q;
    logic [DW-1:0]    s1_dtype_q;
    logic [15:0]      s1_meta_q;

    // Stage 2: knot a and slope d per channel
    logic             s2_valid_q;
    logic [C*P-1:0]   s2_pix_q;
    logic [C-1:0]     s2_map_q;
    logic [DW-1:0]    s2_dtype_q;
    logic [15:0]      s2_meta_q;
    logic [C*P-1:0]   s2_a_q, a_w;
    logic [C*(P+1)-1:0] s2_d_q, d_w;

    // Stage 3: output register
    logic             dvo_q;
    logic [DW-1:0]    dtypeo_q;
    logic [15:0]      meta_datao_q;
    logic [C*P-1:0]   pixo_q, y_w;

    assign shadow_bank = ~active_bank_q;
    assign chan_ok     = ({1'b0, lut_chan} < (CHAN_W+1)'(C));

    // A swap may only land when no pixel is anywhere in the pipe, so a
    // contiguous dvi run always sees a single table.
    assign pipe_busy = s1_valid_q | s2_valid_q | dvo_q;
    assign swap_fire = swap_pending_q & ~dvi & ~pipe_busy;

    always_comb begin
        active_bank_d  = active_bank_q;
        swap_pending_d = swap_pending_q | swap_req;
        if (swap_fire) begin
            active_bank_d  = ~active_bank_q;
            swap_pending_d = swap_req;
        end
    end

    always_comb begin
        lut_rdata_d = '0;
        if (chan_ok) begin
            lut_rdata_d = lut_q[shadow_bank][lut_chan][lut_addr];
        end
    end

    // Writes use the pre-edge shadow bank, so a write on the swap cycle
    // lands in the bank that becomes active.
    always_ff @(posedge pixclk) begin
        if (lut_we && chan_ok) begin
            lut_q[shadow_bank][lut_chan][lut_addr] <= lut_wdata;
        end
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            active_bank_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            lut_rdata_q    <= '0;
            lut_rvalid_q   <= 1'b0;
        end else begin
            active_bank_q  <= active_bank_d;
            swap_pending_q <= swap_pending_d;
            lut_rvalid_q   <= lut_re;
            if (lut_re) begin
                lut_rdata_q <= lut_rdata_d;
            end
        end
    end

    for (genvar k = 0; k < C; k++) begin : g_ch
        localparam logic signed [P+F+1:0] HALF = (P+F+2)'(1) << (F-1);
        localparam logic signed [P+2:0]   YMAX = {3'b000, {P{1'b1}}};

        logic [A-1:0]          idx, idx_n;
        logic [P-1:0]          a_rd, b_rd;
        logic signed [P:0]     d;
        logic [F-1:0]          f;
        logic [P-1:0]          a;
        logic signed [P+F+1:0] prod;
        logic signed [P+2:0]   step;
        logic signed [P+2:0]   sum;
        logic [P-1:0]          clamped;

        // Stage 2 read: the top knot is reused as its own successor.
        assign idx   = s1_pix_q[k*P+F +: A];
        assign idx_n = (idx == '1) ? idx : idx + A'(1);
        assign a_rd  = lut_q[active_bank_q][k][idx];
        assign b_rd  = lut_q[active_bank_q][k][idx_n];
        assign a_w[k*P +: P]         = a_rd;
        assign d_w[k*(P+1) +: (P+1)] = {1'b0, b_rd} - {1'b0, a_rd};

        // Stage 3: y = a + ((d*f + half) >>> F), clamped to [0, 2^P-1].
        assign d    = $signed(s2_d_q[k*(P+1) +: (P+1)]);
        assign f    = s2_pix_q[k*P +: F];
        assign a    = s2_a_q[k*P +: P];
        assign prod = $signed({{(F+1){d[P]}}, d}) * $signed({{(P+2){1'b0}}, f});
        assign step = $signed((P+3)'((prod + HALF) >>> F));
        assign sum  = $signed({3'b000, a}) + step;
        assign clamped = sum[P+2] ? '0 : ((sum > YMAX) ? '1 : sum[P-1:0]);
        assign y_w[k*P +: P] = s2_map_q[k] ? clamped : s2_pix_q[k*P +: P];
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_pix_q     <= '0;
            s1_map_q     <= '0;
            s1_dtype_q   <= '0;
            s1_meta_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_pix_q     <= '0;
            s2_map_q     <= '0;
            s2_dtype_q   <= '0;
            s2_meta_q    <= '0;
            s2_a_q       <= '0;
            s2_d_q       <= '0;
            dvo_q        <= 1'b0;
            dtypeo_q     <= '0;
            meta_datao_q <= '0;
            pixo_q       <= '0;
        end else begin
            s1_valid_q   <= dvi;
            s1_pix_q     <= pixi;
            s1_map_q     <= enable ? ~chan_bypass : '0;
            s1_dtype_q   <= dtypei;
            s1_meta_q    <= meta_datai;
            s2_valid_q   <= s1_valid_q;
            s2_pix_q     <= s1_pix_q;
            s2_map_q     <= s1_map_q;
            s2_dtype_q   <= s1_dtype_q;
            s2_meta_q    <= s1_meta_q;
            s2_a_q       <= a_w;
            s2_d_q       <= d_w;
            dvo_q        <= s2_valid_q;
            dtypeo_q     <= s2_dtype_q;
            meta_datao_q <= s2_meta_q;
            pixo_q       <= y_w;
        end
    end

    assign lut_rdata    = lut_rdata_q;
    assign lut_rvalid   = lut_rvalid_q;
    assign swap_pending = swap_pending_q;
    assign active_bank  = active_bank_q;
    assign dvo          = dvo_q;
    assign dtypeo       = dtypeo_q;
    assign meta_datao   = meta_datao_q;
    assign pixo         = pixo_q;

endmodule

// File: doc/lookup_map_interp.md
# lookup_map_interp

Parametrised successor to the single-LUT pixel mapper. It applies an independent, programmable, linearly interpolated transfer curve to each of `NUM_CHANNELS` pixel channels, using a sparse LUT of `2^LUT_ADDR_WIDTH` knots per channel. LUTs are double-buffered: software programs the shadow bank while the active bank is in use, then requests a glitch-free swap. The block sits in the image pipeline on `pixclk`, and its sideband (`dvi`/`dtype`/`meta_data`) passes through with matched latency.

## Interface
Parameters:
- `PIXEL_WIDTH`, 10: bits per channel sample (P).
- `NUM_CHANNELS`, 3: number of independent channels (C).
- `LUT_ADDR_WIDTH`, 6: log2 knots per channel (A). Requires 1 ≤ A < P. Fractional width is F = P−A.

Ports:
- `pixclk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: 0 makes all channels pass through.
- `chan_bypass` in C: per-channel pass-through.
- `lut_we` in 1: write strobe for the shadow bank.
- `lut_re` in 1: read strobe for the shadow bank.
- `lut_chan` in clog2(C) (min 1): channel select for a LUT access.
- `lut_addr` in A: knot index for a LUT access.
- `lut_wdata` in P: knot value to write.
- `lut_rdata` out P: readback data.
- `lut_rvalid` out 1: readback data valid.
- `swap_req` in 1: single-cycle pulse requesting a bank swap.
- `swap_pending` out 1: a swap has been requested and not yet applied.
- `active_bank` out 1: bank currently used by the datapath.
- `dvi` in 1: input data valid.
- `dtypei` in `DTYPE_WIDTH: input data type (from dtypes.v).
- `meta_datai` in 16: input metadata.
- `pixi` in C·P: input samples; channel k occupies [k·P +: P].
- `dvo` out 1, `dtypeo` out `DTYPE_WIDTH, `meta_datao` out 16, `pixo` out C·P: delayed and mapped outputs.

## Operation
- Knot storage: 2 banks × C channels × 2^A entries × P bits.
  - The datapath needs two simultaneous reads per channel per cycle, at index i and i+1.
  - LUT contents are not cleared by `reset`.
- Per-channel mapping, when `enable`=1 and `chan_bypass[k]`=0:
  - i = x[P-1:F], f = x[F-1:0].
  - a = lut[i], b = lut[min(i+1, 2^A−1)].
  - d = b−a, signed, P+1 bits.
  - y = a + ((d·f + 2^(F-1)) >>> F). The shift is arithmetic, so the result floors.
  - y is clamped to [0, 2^P−1].
- When `enable`=0 or `chan_bypass[k]`=1, y = x for that channel. The pipeline latency is unchanged.
- `enable` and `chan_bypass` are sampled with each pixel at stage 1. A mid-line change takes effect at a pixel boundary, with no partial outputs.
- The sideband is delayed identically to the pixels. `dtypeo` and `meta_datao` are never modified.
- Programming:
  - `lut_we` writes `lut_wdata` into bank !`active_bank` (value before the edge) at [`lut_chan`][`lut_addr`].
  - `lut_re` returns that shadow entry on `lut_rdata`, with `lut_rvalid`=1 one cycle later.
  - If `lut_we` and `lut_re` hit the same entry in the same cycle, the read returns the old data.
  - An out-of-range `lut_chan` (≥C) is ignored: no write, and the read returns 0 with `lut_rvalid`=1.
- Swap handshake:
  - `swap_req` sets `swap_pending`.
  - The swap applies on the first cycle in which `swap_pending`=1, `dvi`=0, and no valid pixel is in any pipeline stage. On that cycle `active_bank` toggles and `swap_pending` clears on the same edge.
  - A `swap_req` while already pending is absorbed, giving one swap only.
  - A `swap_req` on the same cycle that a swap applies re-arms `swap_pending`.
  - A write on the swap cycle targets the pre-swap shadow bank, which therefore becomes active.

## Timing
- Latency: exactly 3 `pixclk` cycles from `dvi`/`pixi` to `dvo`/`pixo`, fully pipelined at 1 pixel per cycle.
  - Stage 1: register the input and split index/fraction.
  - Stage 2: read the knots and compute d.
  - Stage 3: multiply, add, clamp, and register the output.
- While `dvo`=0, the `pixo`, `dtypeo`, and `meta_datao` outputs hold the delayed input values. This is not significant; do not check it.
- Reset values:
  - `dvo`, `dtypeo`, `meta_datao`, `pixo`, `lut_rdata`, `lut_rvalid`, `swap_pending`, and `active_bank` are all 0.
  - All pipeline valid bits are cleared.
- Reset mid-frame: in-flight pixels are dropped, and `dvo`=0 from the cycle after `reset` is asserted.
- After `reset` deasserts, the first output can appear 3 cycles after the first `dvi`=1.
- Swap latency: minimum 1 cycle after `swap_req`, provided the pipeline is already empty.
- A swap never occurs between two pixels of one contiguous `dvi`=1 run. A pending swap waits for the run to end and drain.

## Test plan
- **Interpolation and ramp** (P=10, A=6, F=4):
  - Program bank 1 with lut[5]=100, lut[6]=200, then swap.
  - Drive x=88: y=150 after exactly 3 cycles, and `dvo` aligned.
  - Drive x=80: y=100.
  - A 0..1023 ramp against an identity table lut[n]=16n gives y=x for all x ≤ 1008. Above that, y clamps to lut[63]=1008.
- **Negative slope and edge**:
  - lut[5]=200, lut[6]=100, x=88 gives y=150.
  - lut[63]=777, x=1023 gives y=777.
  - With lut[0]=0, lut[1]=1023, x=1 gives y=64.
- **Per-channel and enable**:
  - Program C=3 with distinct tables and set `chan_bypass`=3'b010: channel 1 equals its input and channels 0 and 2 are mapped.
  - Toggle `enable` mid-line: the change is exact at the pixel boundary, and latency stays 3.
- **Double buffering**:
  - Write the shadow bank during a streaming line: outputs are unchanged.
  - Assert `swap_req` mid-line: `swap_pending`=1 until the line ends and 3 drain cycles pass, then `active_bank` toggles. The next line uses the new table.
  - A second `swap_req` while pending gives a single toggle.
- **Readback**:
  - Write 0x2A5 to chan 2, addr 17, then read: `lut_rdata`=0x2A5 with `lut_rvalid`=1 one cycle later.
  - A read and write to the same address in one cycle returns the old value.
  - `lut_chan`=3 returns 0.
- **Reset mid-operation**:
  - Assert `reset` with 3 pixels in flight and `swap_pending`=1: `dvo`=0 and `swap_pending`=0 next cycle, and `active_bank`=0.
  - Table contents survive the reset and are visible in a readback.
